// File: rtl/core_serial_tx.sv
// Transmit partner of the processing core: buffers 16-bit result words in a small FIFO
// and serializes each one as start + 16 data bits (LSB first) + optional even parity + stop.
`timescale 1ns/1ps
module core_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic [15:0]                   data_in,
    input  logic                          data_in_valid,
    output logic                          tx_done,
    output logic                          serial_out,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CW-1:0]     count_next;
    logic [TMR_W-1:0]  timer;
    logic [3:0]        bit_idx;
    logic [15:0]       shreg;
    logic              par_bit;
    logic              pending_done;
    logic              full;
    logic              empty;
    logic              bit_end;
    logic              push;
    logic              pop;

    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

    assign full    = (fifo_count == DEPTH_C);
    assign empty   = (fifo_count == '0);
    assign bit_end = (timer == TMR_LAST);
    assign tx_busy = !empty || (state != IDLE);

    // Fullness is judged before the pop, so a word arriving on a pop edge always fits.
    assign push = data_in_valid && (!full || pop);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        serial_out = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                serial_out = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                serial_out = shreg[0];
                if (bit_end && bit_idx == 4'd15)
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                serial_out = par_bit;
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                // Chain straight into the next frame when a word is waiting.
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop)
            count_next = fifo_count + 1'b1;
        else if (pop && !push)
            count_next = fifo_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            pending_done <= 1'b0;
            tx_done      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE || bit_end)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (pop)
                bit_idx <= '0;
            else if (state == DATA && bit_end)
                bit_idx <= bit_idx + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_next;
            // A write that fills the buffer owes the core its done pulse until space reopens.
            tx_done <= (push && count_next < DEPTH_C) || (pop && pending_done);
            if (push && count_next == DEPTH_C)
                pending_done <= 1'b1;
            else if (pop)
                pending_done <= 1'b0;
            if (data_in_valid && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
        if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= even_parity(mem[rd_ptr]);
        end else if (state == DATA && bit_end) begin
            shreg <= {1'b0, shreg[15:1]};
        end
    end

endmodule

// File: tb/tb_core_serial_tx.sv
// Bench for core_serial_tx: a line decoder rebuilds frames from the serial output and
// compares them with queues of expected words and parity derived from bit counts.
`timescale 1ns/1ps
module tb_core_serial_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [15:0] data_a = '0, data_b = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        done_a, so_a, busy_a, ovf_a;
    logic        done_b, so_b, busy_b, ovf_b;
    logic [2:0]  cnt_a, cnt_b;

    always #5 clk = ~clk;

    core_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) dut_a (
        .clk(clk), .rstb(rstb), .data_in(data_a), .data_in_valid(valid_a),
        .tx_done(done_a), .serial_out(so_a), .tx_busy(busy_a), .overflow(ovf_a),
        .fifo_count(cnt_a));

    core_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0)) dut_b (
        .clk(clk), .rstb(rstb), .data_in(data_b), .data_in_valid(valid_b),
        .tx_done(done_b), .serial_out(so_b), .tx_busy(busy_b), .overflow(ovf_b),
        .fifo_count(cnt_b));

    typedef struct {
        logic [15:0] word;
        logic        par;
        logic        good;
        int          t;
    } frame_t;

    typedef struct {
        logic [15:0] word;
        logic        par;
        int          busy_cyc;
    } vec_t;

    frame_t      fq_a[$];
    frame_t      fq_b[$];
    logic [15:0] exp_q[$];
    int          cyc = 0;
    int          done_tot_a = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_a === 1'b1) done_tot_a <= done_tot_a + 1;

    // Line decoders: one per instance, sampling every cycle of a frame.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int NB = (g == 0) ? 19 : 18;
        wire line_w = (g == 0) ? so_a : so_b;
        initial begin
            frame_t      f;
            logic [18:0] bits;
            logic        good;
            forever begin
                @(negedge clk);
                if (rstb === 1'b1 && line_w === 1'b0) begin
                    f.t  = cyc;
                    good = 1'b1;
                    bits = '1;
                    for (int b = 0; b < NB; b++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rstb !== 1'b1) good = 1'b0;
                            if (c == 0) bits[b] = line_w;
                            else if (line_w !== bits[b]) good = 1'b0;
                        end
                    end
                    f.word = bits[16:1];
                    f.par  = (NB == 19) ? bits[17] : 1'b0;
                    f.good = good && (bits[0] == 1'b0) && (bits[NB-1] == 1'b1);
                    if (g == 0) fq_a.push_back(f);
                    else        fq_b.push_back(f);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input int which, input logic [15:0] w);
        @(negedge clk);
        if (which == 0) begin data_a = w; valid_a = 1'b1; end
        else            begin data_b = w; valid_b = 1'b1; end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    function automatic int fq_size(input int which);
        return (which == 0) ? fq_a.size() : fq_b.size();
    endfunction

    task automatic wait_done_a(inout int timeouts);
        int k = 0;
        while (done_a !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        if (k >= 300) timeouts++;
    endtask

    // Compare decoded frames with exp_q; spacing > 0 also demands back-to-back frames.
    task automatic check_frames(input string name, input int which, input int budget, input int spacing);
        frame_t got[$];
        int k = 0, n, bw = 0, bp = 0, bf = 0, bs = 0;
        while (fq_size(which) < exp_q.size() && k < budget) begin @(negedge clk); k++; end
        idle(100);
        if (which == 0) got = fq_a; else got = fq_b;
        check({name, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got[i].word !== exp_q[i]) bw++;
            if (which == 0 && got[i].par !== ($countones(exp_q[i]) % 2 == 1)) bp++;
            if (got[i].good !== 1'b1) bf++;
            if (spacing > 0 && i > 0 && got[i].t - got[i-1].t != spacing) bs++;
        end
        check({name, "_word_errs"}, bw, 0);
        check({name, "_parity_errs"}, bp, 0);
        check({name, "_framing_errs"}, bf, 0);
        if (spacing > 0) check({name, "_gap_errs"}, bs, 0);
        if (which == 0) fq_a.delete(); else fq_b.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [18:0] line_exp;
        logic [15:0] bp_w[4];
        logic [15:0] w;
        frame_t      f;
        int          k, n, errs, busy_err, timeouts, done0, ts;

        tbl[0] = '{16'hA5C3, 1'b0, 77};
        tbl[1] = '{16'h0001, 1'b1, 77};
        tbl[2] = '{16'hFFFF, 1'b0, 77};
        tbl[3] = '{16'h0000, 1'b0, 77};
        tbl[4] = '{16'h8000, 1'b1, 77};
        tbl[5] = '{16'h7FFF, 1'b1, 77};
        bp_w[0] = 16'h0102; bp_w[1] = 16'h7001; bp_w[2] = 16'hBEEF; bp_w[3] = 16'h0F0E;

        // Power-on reset
        idle(3);
        check("rst_line", 32'(so_a), 1);
        check("rst_done", 32'(done_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_count", 32'(cnt_a), 0);
        check("rst_busy_b", 32'(busy_b), 0);
        rstb = 1'b1;
        idle(2);

        // Single word A5C3, cycle-accurate line shape
        line_exp = {1'b1, 1'b0, 16'hA5C3, 1'b0};
        @(negedge clk); data_a = 16'hA5C3; valid_a = 1'b1;
        @(negedge clk); valid_a = 1'b0;
        check("single_done", 32'(done_a), 1);
        check("single_count", 32'(cnt_a), 1);
        check("single_line_idle", 32'(so_a), 1);
        @(negedge clk);
        check("single_done_width", 32'(done_a), 0);
        check("single_start", 32'(so_a), 0);
        errs = 0; busy_err = 0;
        for (int i = 0; i < 19 * CPB; i++) begin
            if (so_a !== line_exp[i / CPB]) errs++;
            if (busy_a !== 1'b1) busy_err++;
            @(negedge clk);
        end
        check("single_bit_errs", errs, 0);
        check("single_busy_errs", busy_err, 0);
        check("single_busy_end", 32'(busy_a), 0);
        check("single_line_end", 32'(so_a), 1);
        exp_q = {16'hA5C3};
        check_frames("single", 0, 50, 0);

        // Table of isolated words: decoded word, parity bit, busy duration
        for (int i = 0; i < 6; i++) begin
            write(0, tbl[i].word);
            n = 0;
            while (busy_a === 1'b1 && n < 200) begin n++; @(negedge clk); end
            check("tbl_busy_cycles", n, tbl[i].busy_cyc);
            k = 0;
            while (fq_a.size() == 0 && k < 50) begin @(negedge clk); k++; end
            check("tbl_frame_seen", fq_a.size(), 1);
            if (fq_a.size() > 0) begin
                f = fq_a.pop_front();
                check("tbl_word", 32'(f.word), 32'(tbl[i].word));
                check("tbl_parity", 32'(f.par), 32'(tbl[i].par));
                check("tbl_framing", 32'(f.good), 1);
            end
            fq_a.delete();
            idle(3);
        end

        // Core emulation: 0x0000..0x007F, each after the previous tx_done
        exp_q.delete();
        timeouts = 0;
        done0 = done_tot_a;
        for (int i = 0; i < 128; i++) begin
            write(0, 16'(i));
            exp_q.push_back(16'(i));
            wait_done_a(timeouts);
        end
        check("core_done_timeouts", timeouts, 0);
        check_frames("core", 0, 128 * 80, 19 * CPB);
        check("core_done_pulses", done_tot_a - done0, 128);
        check("core_overflow", 32'(ovf_a), 0);

        // Random words, random gaps including idle stretches
        exp_q.delete();
        timeouts = 0;
        done0 = done_tot_a;
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            write(0, w);
            exp_q.push_back(w);
            wait_done_a(timeouts);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(60, 120));
            else                           idle($urandom_range(0, 3));
        end
        check("rand_done_timeouts", timeouts, 0);
        check_frames("rand", 0, 40 * 200, 0);
        check("rand_done_pulses", done_tot_a - done0, 40);

        // Back-pressure and overflow while a frame is on the line
        write(0, 16'h1111);
        k = 0;
        while (so_a !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("bp_started", 32'(so_a), 0);
        @(negedge clk); data_a = bp_w[0]; valid_a = 1'b1;
        @(negedge clk); check("bp_done1", 32'(done_a), 1); data_a = bp_w[1];
        @(negedge clk); check("bp_done2", 32'(done_a), 1); data_a = bp_w[2];
        @(negedge clk); check("bp_done3", 32'(done_a), 1); data_a = bp_w[3];
        @(negedge clk);
        check("bp_done4_withheld", 32'(done_a), 0);
        check("bp_full_count", 32'(cnt_a), 4);
        data_a = 16'hFFFF;
        @(negedge clk); valid_a = 1'b0;
        check("ovf_set", 32'(ovf_a), 1);
        check("ovf_count", 32'(cnt_a), 4);
        check("ovf_no_done", 32'(done_a), 0);
        k = 0; errs = 0;
        while (cnt_a === 3'd4 && k < 200) begin
            if (done_a === 1'b1) errs++;
            @(negedge clk); k++;
        end
        check("bp_early_done", errs, 0);
        check("bp_pop_count", 32'(cnt_a), 3);
        check("bp_pending_done", 32'(done_a), 1);
        @(negedge clk);
        check("bp_pending_width", 32'(done_a), 0);
        exp_q = {16'h1111, bp_w[0], bp_w[1], bp_w[2], bp_w[3]};
        check_frames("bp", 0, 600, 19 * CPB);
        check("ovf_sticky", 32'(ovf_a), 1);

        // Push on the STOP->START pop edge with a full FIFO, no-parity instance
        write(1, 16'hC001);
        k = 0;
        while (so_b !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("sim_started", 32'(so_b), 0);
        ts = cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); data_b = bp_w[3 - i]; valid_b = 1'b1;
        end
        @(negedge clk); valid_b = 1'b0;
        check("sim_full", 32'(cnt_b), 4);
        while (cyc < ts + 71) @(negedge clk);
        check("sim_last_stop", 32'(so_b), 1);
        data_b = 16'hD00D; valid_b = 1'b1;
        @(negedge clk); valid_b = 1'b0;
        check("sim_count", 32'(cnt_b), 4);
        check("sim_no_ovf", 32'(ovf_b), 0);
        check("sim_next_start", 32'(so_b), 0);
        check("sim_pending_done", 32'(done_b), 1);
        exp_q = {16'hC001, bp_w[3], bp_w[2], bp_w[1], bp_w[0], 16'hD00D};
        check_frames("sim", 1, 1000, 18 * CPB);

        // Reset in the middle of a frame
        write(0, 16'h1234);
        idle(30);
        rstb = 1'b0;
        idle(3);
        check("midrst_line", 32'(so_a), 1);
        rstb = 1'b1;
        idle(1);
        check("midrst_line_after", 32'(so_a), 1);
        check("midrst_done", 32'(done_a), 0);
        check("midrst_count", 32'(cnt_a), 0);
        check("midrst_ovf", 32'(ovf_a), 0);
        check("midrst_busy", 32'(busy_a), 0);
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if (so_a !== 1'b1) errs++;
            @(negedge clk);
        end
        check("midrst_line_quiet", errs, 0);
        fq_a.delete();
        exp_q = {16'h4321};
        write(0, 16'h4321);
        check_frames("post_rst", 0, 200, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_serial_tx.md
Name: core_serial_tx

Overview:
- Transmit-side partner of the processing core's output channel.
- Accepts 16-bit result words on the core's data_out/data_out_valid strobe and buffers them in a small FIFO.
- Serializes each word onto a single idle-high line as a framed asynchronous character: start bit, 16 data bits LSB first, optional parity bit, stop bit.
- Returns the tx_done pulse the core waits on before presenting its next word.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, word buffer depth; power of two, minimum 2.
- PARITY_EN, 1, 1 = insert even-parity bit after data, 0 = no parity bit.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstb  in  1  synchronous active-low reset.
- data_in  in  16  word from core (core's data_out).
- data_in_valid  in  1  one-cycle write strobe from core (core's data_out_valid).
- tx_done  out  1  one-cycle pulse: word accepted and buffer space exists for the next one.
- serial_out  out  1  serial line; idle high.
- tx_busy  out  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  out  1  sticky: a write arrived while the FIFO was full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rstb=0 at posedge) forces:
  - serial_out=1, tx_done=0, tx_busy=0, overflow=0, fifo_count=0.
  - FIFO pointers cleared, pending_done=0, shifter state IDLE.
  - Reset mid-frame aborts the frame immediately; the line returns high on the same edge.
- Write:
  - At a posedge with data_in_valid=1 and FIFO not full, data_in is pushed.
  - If fifo_count after the edge < FIFO_DEPTH, tx_done=1 for exactly the next cycle.
  - Otherwise pending_done is set. tx_done pulses one cycle in the cycle after the next pop, then pending_done clears.
- Full write: data_in_valid=1 while full drops the word, sets overflow (sticky until reset), and produces no tx_done.
- Simultaneous push and pop in one cycle: both occur; fifo_count is unchanged; fullness is judged before the pop, so a push to a full FIFO being popped in that same cycle is accepted.
- Pointers wrap modulo FIFO_DEPTH.
- Shifter FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial_out=1. If the FIFO is non-empty, pop the head into a 16-bit shift register, compute parity = XOR of the word, go to START. The pop happens on the edge after the word became visible, so an empty-FIFO write reaches the line start bit 1 cycle after capture.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: serial_out = shreg[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 15, go to PARITY if PARITY_EN, else STOP.
  - PARITY: serial_out = even-parity bit (XOR of the 16 data bits) for CLKS_PER_BIT cycles.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START (no extra idle cycles); else go to IDLE.
- Frame length is (18 + PARITY_EN) * CLKS_PER_BIT cycles exactly.
- Bit timer: counts 0..CLKS_PER_BIT-1, reset on every state or bit change; no drift across frames.
- tx_busy = (fifo_count != 0) | (state != IDLE).
- data_in is ignored when data_in_valid=0. A held-high data_in_valid pushes once per cycle; this is legal and is the designer's responsibility.

Test Plan:
- Reset check: hold rstb=0 for 3 cycles mid-frame, then release.
  - Required: serial_out=1, tx_done=0, fifo_count=0, overflow=0.
  - No start bit until a new write.
- Single word, CLKS_PER_BIT=4, PARITY_EN=1, write 16'hA5C3.
  - tx_done pulses 1 cycle after capture.
  - Start bit begins 1 cycle after capture.
  - Line bits: 0 | 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 | parity 0 | 1.
  - Each bit lasts 4 cycles; 76 cycles total; tx_busy drops after the stop bit.
- Core emulation: drive 128 words 16'h0000..16'h007F, each written only after the previous tx_done rising edge.
  - All 128 frames appear back-to-back in order with correct parity.
  - Exactly 128 tx_done pulses; overflow stays 0.
- Back-pressure, FIFO_DEPTH=4: write 4 words on consecutive cycles while the line is busy.
  - First 3 writes give tx_done; the 4th sets pending_done with no tx_done.
  - tx_done pulses 1 cycle after the first pop.
- Overflow: with the FIFO full and no pop that cycle, write 16'hFFFF.
  - overflow=1 and stays high; the word never appears on the line.
  - fifo_count remains 4.
- Simultaneous push and pop at the STOP→START boundary with a full FIFO.
  - Word is accepted and fifo_count stays 4.
  - Ordering is preserved; PARITY_EN=0 run shows a 72-cycle frame.
